// File: rtl/axis_bpsk_eq.sv
// axis_bpsk_eq: one-tap BPSK channel equalizer; trains H[k] on the first symbol of a frame.
// Define AXIS_BPSK_EQ_SAT_EN to saturate equalized outputs instead of wrapping.
module axis_bpsk_eq #(
   parameter int N_SC  = 64,
   parameter int SHIFT = 12
) (
   input  logic        aclk,
   input  logic        areset,
   output logic        s_axis_tready,
   input  logic [47:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   input  logic        m_axis_tready,
   output logic [47:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        en,
   output logic        trained
);
   localparam int CW = (N_SC > 1) ? $clog2(N_SC) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(N_SC - 1);

   typedef enum logic {S_TRAIN, S_EQ} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [45:0]        h_mem [N_SC];
   logic [45:0]        h_word;
   logic signed [22:0] y_re, y_im, h_re, h_im;
   logic signed [45:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
   logic               v1_q, last1_q;
   logic               mvalid_q, mlast_q;
   logic [47:0]        mdata_q;
   logic               ce, acc, acc_eq;
   logic signed [46:0] sum_re, sum_im, sh_re, sh_im;
   logic [22:0]        o_re, o_im;
   logic               unused;

   assign ce            = en & (~mvalid_q | m_axis_tready);
   assign s_axis_tready = (state_q == S_TRAIN) ? en : ce;
   assign acc           = s_axis_tvalid & s_axis_tready;
   assign acc_eq        = acc & (state_q == S_EQ);
   assign trained       = (state_q == S_EQ);
   assign m_axis_tvalid = mvalid_q;
   assign m_axis_tlast  = mlast_q;
   assign m_axis_tdata  = mdata_q;

   assign y_re   = s_axis_tdata[22:0];
   assign y_im   = s_axis_tdata[46:24];
   assign h_word = h_mem[cnt_q];
   assign h_re   = h_word[45:23];
   assign h_im   = h_word[22:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (acc) begin
         // tlast always ends the frame, even a short training symbol
         if (s_axis_tlast) begin
            state_d = S_TRAIN;
            cnt_d   = '0;
         end else if (cnt_q == CNT_MAX) begin
            state_d = S_EQ;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= S_TRAIN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (acc && state_q == S_TRAIN)
         h_mem[cnt_q] <= {s_axis_tdata[22:0], s_axis_tdata[46:24]};
   end

   always_ff @(posedge aclk) begin
      if (acc_eq) begin
         p_rr_q <= 46'(y_re) * 46'(h_re);
         p_ii_q <= 46'(y_im) * 46'(h_im);
         p_ir_q <= 46'(y_im) * 46'(h_re);
         p_ri_q <= 46'(y_re) * 46'(h_im);
      end
   end

   assign sum_re = {p_rr_q[45], p_rr_q} + {p_ii_q[45], p_ii_q};
   assign sum_im = {p_ir_q[45], p_ir_q} - {p_ri_q[45], p_ri_q};
   assign sh_re  = sum_re >>> SHIFT;
   assign sh_im  = sum_im >>> SHIFT;

`ifdef AXIS_BPSK_EQ_SAT_EN
   function automatic logic [22:0] narrow(input logic signed [46:0] v);
      logic [22:0] r;
      r = v[22:0];
      if (v > 47'sd4194303)
         r = 23'h3FFFFF;
      else if (v < -47'sd4194304)
         r = 23'h400000;
      return r;
   endfunction

   assign o_re   = narrow(sh_re);
   assign o_im   = narrow(sh_im);
   assign unused = s_axis_tdata[47] ^ s_axis_tdata[23];
`else
   assign o_re   = sh_re[22:0];
   assign o_im   = sh_im[22:0];
   assign unused = ^{s_axis_tdata[47], s_axis_tdata[23],
                     sh_re[46:23], sh_im[46:23]};
`endif

   always_ff @(posedge aclk) begin
      if (areset) begin
         v1_q     <= 1'b0;
         last1_q  <= 1'b0;
         mvalid_q <= 1'b0;
         mlast_q  <= 1'b0;
         mdata_q  <= '0;
      end else if (ce) begin
         v1_q     <= acc_eq;
         last1_q  <= acc_eq & s_axis_tlast;
         mvalid_q <= v1_q;
         mlast_q  <= v1_q & last1_q;
         if (v1_q)
            mdata_q <= {1'b0, o_im, 1'b0, o_re};
      end
   end
endmodule
